// File: rtl/led_arbiter_if.sv
// LED bank arbitration bus: requests, release strobes and patterns go in;
// grant, LED drive and status come out.
interface led_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  rel;
    logic [17:0] pattern_in;
    logic [2:0]  gnt;
    logic [5:0]  led;
    logic        busy;
    logic        timeout;

    modport master (output req, rel, pattern_in, input gnt, led, busy, timeout);
    modport slave  (input req, rel, pattern_in, output gnt, led, busy, timeout);
endinterface

// File: rtl/led_arbiter.sv
// Three-requester round-robin arbiter for a shared 6-bit LED bank.
// Ownership is held for at least MIN_HOLD ticks and is forcibly revoked
// after MAX_HOLD ticks. A one-cycle dark gap separates owners.
module led_arbiter #(
    parameter int TICK_DIV = 27000,
    parameter int MIN_HOLD = 100,
    parameter int MAX_HOLD = 2000
) (
    input  logic         clk,
    input  logic         rst_n,
    led_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     hold_q, hold_d;
    logic            relq_q, relq_d;
    logic            rdy_q;
    logic [2:0]      gnt_q, gnt_d;
    logic [5:0]      led_q, led_d;
    logic            to_q, to_d;

    logic [2:0]      own_mask;
    logic            own_rel;
    logic            rel_pend;
    logic            tick;
    logic            forced;
    logic            vol;
    logic [1:0]      win;
    logic [5:0]      slice;
    logic [1:0]      ord_a, ord_b, ord_c;

    assign own_mask = 3'b001 << owner_q;
    // Owner wants out if it strobes rel or drops its req.
    assign own_rel  = (|(bus.rel & own_mask)) | ~(|(bus.req & own_mask));
    assign rel_pend = relq_q | own_rel;
    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    // Forced release fires on the edge where hold_cnt would reach MAX_HOLD.
    assign forced   = tick && (hold_q >= 16'(MAX_HOLD - 1));
    assign vol      = rel_pend && (hold_q >= 16'(MIN_HOLD));

    // Round-robin search order, starting just after the previous owner.
    always_comb begin
        ord_a = 2'd0;
        ord_b = 2'd1;
        ord_c = 2'd2;
        case (last_q)
            2'd0:    begin ord_a = 2'd1; ord_b = 2'd2; ord_c = 2'd0; end
            2'd1:    begin ord_a = 2'd2; ord_b = 2'd0; ord_c = 2'd1; end
            default: begin ord_a = 2'd0; ord_b = 2'd1; ord_c = 2'd2; end
        endcase
        if (bus.req[ord_a])      win = ord_a;
        else if (bus.req[ord_b]) win = ord_b;
        else                     win = ord_c;
    end

    // Owner's pattern slice, passed straight through to led next cycle.
    always_comb begin
        case (owner_q)
            2'd0:    slice = bus.pattern_in[5:0];
            2'd1:    slice = bus.pattern_in[11:6];
            default: slice = bus.pattern_in[17:12];
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        presc_d = presc_q;
        hold_d  = hold_q;
        relq_d  = relq_q;
        gnt_d   = 3'b000;
        led_d   = 6'b000000;
        to_d    = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                // GAP already holds the updated last owner, so it arbitrates
                // directly; this keeps the dark interval to a single cycle.
                state_d = IDLE;
                if (rdy_q && (|bus.req)) begin
                    state_d = OWNED;
                    owner_d = win;
                    gnt_d   = 3'b001 << win;
                    presc_d = '0;
                    hold_d  = '0;
                    relq_d  = 1'b0;
                end
            end
            OWNED: begin
                if (forced || vol) begin
                    state_d = GAP;
                    last_d  = owner_q;
                    to_d    = forced;
                    relq_d  = 1'b0;
                end else begin
                    gnt_d  = gnt_q;
                    led_d  = slice;
                    relq_d = rel_pend;
                    if (tick) begin
                        presc_d = '0;
                        hold_d  = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            presc_q <= '0;
            hold_q  <= '0;
            relq_q  <= 1'b0;
            gnt_q   <= 3'b000;
            led_q   <= 6'b000000;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            relq_q  <= relq_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            to_q    <= to_d;
        end
    end

    // Blocks grants on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign bus.gnt     = gnt_q;
    assign bus.led     = led_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: stimulus pushes model expectations,
// a monitor pops and compares one entry per clock.
module tb_led_arbiter;
    localparam int TD   = 4;
    localparam int MINH = 2;
    localparam int MAXH = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_arbiter_if bus ();

    led_arbiter #(.TICK_DIV(TD), .MIN_HOLD(MINH), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] gnt;
        logic [5:0] led;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: owner index (-1 = none), cycles owned, pending release.
    int         m_own  = -1;
    int         m_n    = 0;
    int         m_last = 2;
    bit         m_pend = 0;
    bit         m_rdy  = 0;
    logic [5:0] m_led  = '0;
    bit         m_to   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    function automatic int rr(input int last, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge and queue the expected outputs.
    task automatic model_step(input logic rst, input logic [2:0] r, input logic [2:0] l,
                              input logic [17:0] p);
        exp_t e;
        if (!rst) begin
            m_own = -1; m_n = 0; m_last = 2; m_pend = 0; m_rdy = 0; m_led = '0; m_to = 0;
        end else if (!m_rdy) begin
            m_rdy = 1; m_to = 0; m_led = '0;
        end else if (m_own >= 0) begin
            int  hold, newhold;
            bit  forced, want;
            hold    = m_n / TD;
            newhold = (m_n + 1) / TD;
            forced  = (((m_n + 1) % TD) == 0) && (newhold >= MAXH);
            want    = m_pend || l[m_own] || !r[m_own];
            if (forced || (want && hold >= MINH)) begin
                m_last = m_own; m_own = -1; m_to = forced; m_led = '0; m_pend = 0;
            end else begin
                m_pend = want; m_n++; m_led = p[6*m_own +: 6]; m_to = 0;
            end
        end else begin
            m_to = 0; m_led = '0;
            if (r != 3'b000) begin
                m_own = rr(m_last, r); m_n = 0; m_pend = 0;
            end
        end
        e.gnt  = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        e.led  = m_led;
        e.busy = (m_own >= 0);
        e.to   = m_to;
        q.push_back(e);
    endtask

    task automatic cycle(input logic rst, input logic [2:0] r, input logic [2:0] l,
                         input logic [17:0] p);
        @(negedge clk);
        rst_n          = rst;
        bus.req        = r;
        bus.rel        = l;
        bus.pattern_in = p;
        model_step(rst, r, l, p);
    endtask

    task automatic rst_check(input string tag);
        check({tag, "_gnt"},  32'(bus.gnt), 32'd0);
        check({tag, "_led"},  32'(bus.led), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_to"},   32'(bus.timeout), 32'd0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 3'b000, 3'b000, 18'($urandom));
        #1 rst_check("rst");
        cycle(1'b0, 3'b000, 3'b000, 18'($urandom));
        cycle(1'b1, 3'b000, 3'b000, 18'($urandom));
    endtask

    // Monitor: one expectation per rising edge, compared 2 time units later.
    exp_t mon_e;
    initial begin
        @(negedge clk);
        forever begin
            @(posedge clk);
            #2;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: actual=empty required=entry @%0t", $time);
            end else begin
                mon_e = q.pop_front();
                check("gnt",     32'(bus.gnt),     32'(mon_e.gnt));
                check("led",     32'(bus.led),     32'(mon_e.led));
                check("busy",    32'(bus.busy),    32'(mon_e.busy));
                check("timeout", 32'(bus.timeout), 32'(mon_e.to));
            end
        end
    end

    logic [2:0]  r, l;
    logic [17:0] p;
    bit          hit;

    initial begin
        bus.req = '0; bus.rel = '0; bus.pattern_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 rst_check("por");
        do_reset();

        // Round-robin with all requesting; owner releases after 10 cycles.
        repeat (80) begin
            r = 3'b111;
            l = (m_own >= 0 && m_n == 10) ? 3'(1 << m_own) : 3'b000;
            cycle(1'b1, r, l, 18'($urandom));
        end

        // Early release by requester 1 is deferred to MIN_HOLD.
        do_reset();
        repeat (40) begin
            l = (m_own == 1 && m_n == 2) ? 3'b010 : 3'b000;
            p = {6'($urandom), 6'h2A, 6'($urandom)};
            cycle(1'b1, 3'b010, l, p);
        end

        // Lone holder never releases: timeout and re-grant.
        do_reset();
        repeat (60) cycle(1'b1, 3'b001, 3'b000, 18'($urandom));

        // Two permanent holders alternate via timeouts.
        do_reset();
        repeat (90) cycle(1'b1, 3'b101, 3'b000, 18'($urandom));

        // Reset in the middle of ownership.
        do_reset();
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (m_own >= 0 && m_n == 5) hit = 1;
            else cycle(1'b1, 3'b111, 3'b000, 18'($urandom));
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL mid_owned_wait: actual=timeout required=owned");
        end
        cycle(1'b0, 3'b111, 3'b000, 18'($urandom));
        #1 rst_check("mid_rst");
        cycle(1'b0, 3'b111, 3'b000, 18'($urandom));
        repeat (30) cycle(1'b1, 3'b111, 3'b000, 18'($urandom));

        // Owner drops req at the MIN_HOLD tick while a non-owner strobes rel.
        do_reset();
        repeat (60) begin
            r = (m_own == 0 && m_n >= 7) ? 3'b000 : 3'b001;
            l = (m_own == 0 && m_n == 7) ? 3'b100 : 3'b000;
            cycle(1'b1, r, l, 18'($urandom));
        end

        // Random traffic with occasional resets.
        do_reset();
        repeat (400) begin
            r = 3'($urandom);
            l = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            cycle(($urandom_range(0, 99) != 0), r, l, 18'($urandom));
        end

        @(posedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 27000, clk cycles per hold tick (1 ms at 27 MHz).
REQ-002 SHALL have parameter MIN_HOLD, default 100, minimum ownership in ticks before a voluntary release takes effect.
REQ-003 SHALL have parameter MAX_HOLD, default 2000, ownership limit in ticks, after which release is forced; MAX_HOLD > MIN_HOLD ≥ 1.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  3  per-requester ownership request for the LED bank; level-sensitive.
REQ-007 rel  input  3  per-requester voluntary release strobe; only the owner's bit is honoured.
REQ-008 pattern_in  input  18  three 6-bit patterns; requester i drives bits [6i+5:6i].
REQ-009 gnt  output  3  one-hot or zero grant, registered.
REQ-010 led  output  6  registered LED drive.
REQ-011 busy  output  1  high whenever gnt is non-zero.
REQ-012 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have three states: IDLE, OWNED and GAP.
REQ-014 In IDLE with any req bit high, the block SHALL set gnt to the winner on the next edge and enter OWNED; gnt rises 1 cycle after req is sampled.
REQ-015 Arbitration SHALL be round-robin: search order starts at last_owner+1 (mod 3). After reset, last_owner = 2, so requester 0 has first priority.
REQ-016 In OWNED, led SHALL be loaded every cycle with the owner's pattern slice; latency pattern_in -> led is 1 cycle.
REQ-017 In IDLE and GAP, led SHALL be 6'b000000.
REQ-018 On grant, the prescaler SHALL reset to 0 and hold_cnt SHALL reset to 0.
REQ-019 hold_cnt SHALL increment on each prescaler wrap (every TICK_DIV cycles). It is 16 bits wide and saturates, never wrapping.
REQ-020 A release request SHALL be latched when the owner's rel bit is high or the owner's req bit is low.
REQ-021 The latched release SHALL take effect on the first cycle where it is set and hold_cnt ≥ MIN_HOLD, giving a transition to GAP.
REQ-022 A release before MIN_HOLD SHALL be deferred, not dropped; the owner keeps gnt and led until MIN_HOLD.
REQ-023 When hold_cnt reaches MAX_HOLD, the block SHALL enter GAP and pulse timeout for 1 cycle, regardless of req or rel.
REQ-024 If voluntary and forced release coincide, the release SHALL be treated as forced (timeout pulses).
REQ-025 GAP SHALL last exactly 1 cycle, with gnt = 0 and led = 0. last_owner is updated to the released owner, then the FSM returns to IDLE.
REQ-026 A requester that was released or timed out and still holds req SHALL be re-granted only if no other requester has req high in IDLE.
REQ-027 rel bits of non-owners and rel while in IDLE or GAP SHALL be ignored.
REQ-028 Changes to pattern_in during OWNED SHALL appear on led one cycle later; no pattern is latched at grant.

Reset
REQ-029 While rst_n is low, outputs SHALL be forced asynchronously: gnt = 0, led = 0, busy = 0, timeout = 0. State SHALL be IDLE, last_owner = 2, prescaler = 0, hold_cnt = 0 and the release latch cleared.
REQ-030 Reset asserted mid-OWNED SHALL drop gnt and led in the same cycle, without a GAP cycle or timeout pulse.
REQ-031 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising clk edge.

Verification (TICK_DIV=4, MIN_HOLD=2, MAX_HOLD=5)
REQ-032 Stimulus: req = 3'b111 held, each owner pulses rel after 10 cycles. Required response: gnt sequence 001 -> 010 -> 100 -> 001, with a 1-cycle gnt = 0 between each grant.
REQ-033 Stimulus: req[1] only, pattern_in[11:6] = 6'h2A, rel[1] pulsed 2 cycles after grant. Required response: led = 6'h2A from grant+1, gnt held until hold_cnt = 2 (8 cycles after grant), then GAP.
REQ-034 Stimulus: req[0] held, rel never pulsed. Required response: timeout pulses once 20 cycles after gnt rises, gnt = 0 for 1 cycle, then gnt = 001 is re-granted.
REQ-035 Stimulus: req[0] and req[2] held, both never release. Required response: alternating grants 001, 100, 001 with a timeout each time; requester 0 is never granted twice in a row.
REQ-036 Stimulus: rst_n pulled low mid-OWNED. Required response: gnt = 0 and led = 0 immediately; no timeout pulse; after release, requester 0 wins first.
REQ-037 Stimulus: owner's req drops and rel[2] (non-owner) is pulsed at the same time as the MIN_HOLD tick. Required response: voluntary release at hold_cnt = 2, no timeout, rel[2] has no effect.
